hp_manager: RTL and testbench
=============================

HP_MANAGER -- requirements
Module: hp_manager

Interface
REQ-001 Parameter HP_INIT, default 5, starting HP for each player (1..15).
REQ-002 Parameter DMG, default 1, HP lost by the loser of a round (1..15).
REQ-003 Parameter DRAW_DMG, default 1, HP lost by each player on a draw (0..15).
REQ-004 The block SHALL use one clock, and its reset SHALL be asynchronous and active-low.
REQ-005 CLK  input  1  system clock; all state changes on its rising edge.
REQ-006 RST  input  1  asynchronous active-low reset.
REQ-007 START  input  1  level; sampled in IDLE and OVER to begin a new game.
REQ-008 WL_IN  input  3  round result from the win/lose judge: 000 none, 001 self wins, 010 enemy wins, 011 draw, 1xx invalid.
REQ-009 MY_HP  output  4  own HP, registered.
REQ-010 EN_HP  output  4  enemy HP, registered.
REQ-011 ROUND_DONE  output  1  one-cycle pulse when a round result is applied.
REQ-012 NEXT_Q  output  1  one-cycle pulse requesting the next question.
REQ-013 GAME_OVER  output  1  level; high while in OVER.
REQ-014 RESULT  output  2  final outcome: 00 none, 01 self wins, 10 enemy wins, 11 draw.

Function
REQ-015 The FSM SHALL have the states IDLE, PLAY, HIT, WAIT_CLR and OVER.
REQ-016 IDLE: MY_HP=EN_HP=HP_INIT; START=1 moves to PLAY and pulses NEXT_Q in the same cycle.
REQ-017 PLAY: a WL_IN value of 001, 010 or 011 SHALL be registered and move the FSM to HP; values 000 and 1xx SHALL be ignored.
REQ-018 HIT (one cycle): apply damage from the registered code and pulse ROUND_DONE.
  - 001: EN_HP -= DMG.
  - 010: MY_HP -= DMG.
  - 011: both HP -= DRAW_DMG.
REQ-019 All subtraction SHALL saturate at 0 and never wrap.
REQ-020 HP updates SHALL be visible on the outputs the cycle after HIT, which is 2 cycles after WL_IN is first sampled nonzero in PLAY.
REQ-021 After HIT, the FSM SHALL go to OVER if either post-damage HP is 0, else to WAIT_CLR.
REQ-022 WAIT_CLR: WL_IN held nonzero for any number of cycles SHALL NOT apply further damage.
  - On WL_IN=000, return to PLAY and pulse NEXT_Q.
REQ-023 OVER: GAME_OVER=1 and the HP outputs are frozen.
  - RESULT=01 if EN_HP=0 and MY_HP>0.
  - RESULT=10 if MY_HP=0 and EN_HP>0.
  - RESULT=11 if both are 0.
REQ-024 OVER: START=1 SHALL reload both HP to HP_INIT, clear RESULT and GAME_OVER, enter PLAY and pulse NEXT_Q.
REQ-025 START SHALL be ignored in PLAY, HIT and WAIT_CLR.
REQ-026 In all states other than OVER, RESULT SHALL be 00.
REQ-027 ROUND_DONE and NEXT_Q SHALL never be high in the same cycle, and each SHALL be at most one cycle wide per event.
REQ-028 If WL_IN changes directly from one nonzero code to another while in WAIT_CLR, the change SHALL be ignored; the judge must pass through 000 between rounds.

Reset
REQ-029 RST low SHALL force, asynchronously, state=IDLE, MY_HP=EN_HP=HP_INIT, ROUND_DONE=0, NEXT_Q=0, GAME_OVER=0, RESULT=00 and the registered code=000.
REQ-030 Reset asserted mid-round, including in HIT, SHALL discard any pending damage.
REQ-031 After reset release, the first START sample SHALL occur on the next rising edge of CLK.

Verification
REQ-032 Basic round: reset, START=1 for 1 cycle, WL_IN=001 for 3 cycles then 000 -> EN_HP 5->4, MY_HP=5, exactly one ROUND_DONE, NEXT_Q pulses at start and after clear.
REQ-033 Held input: WL_IN=010 held 10 cycles -> MY_HP=4 only (single decrement), no NEXT_Q until WL_IN=000.
REQ-034 Enemy win: five 010 rounds separated by 000 -> MY_HP=0, GAME_OVER=1, RESULT=10, no NEXT_Q after the final HIT; further WL_IN has no effect.
REQ-035 Double KO: HP_INIT=1, DRAW_DMG=1, WL_IN=011 -> MY_HP=EN_HP=0, RESULT=11.
  - With DMG=3, HP_INIT=2: one 001 round -> EN_HP=0 (saturated), RESULT=01.
REQ-036 Invalid code and restart: WL_IN=100 or 111 in PLAY -> no state change; START in OVER -> HP back to HP_INIT, RESULT=00, NEXT_Q pulse.
REQ-037 Reset mid-game: RST low during HIT -> all outputs at reset values immediately (asynchronously), with no damage applied.

Source files
------------

// File: rtl/hp_manager.sv
// hp_manager: tracks both players' HP across quiz rounds scored by the win/lose judge.
// Latency: HP changes are visible 2 cycles after a result code is sampled in PLAY; NEXT_Q follows its trigger edge by one cycle.
// Backpressure: none; a held judge code is absorbed in WAIT_CLR until the judge returns to 000.
module hp_manager #(
   parameter int HP_INIT  = 5,
   parameter int DMG      = 1,
   parameter int DRAW_DMG = 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic [2:0] WL_IN,
   output logic [3:0] MY_HP,
   output logic [3:0] EN_HP,
   output logic       ROUND_DONE,
   output logic       NEXT_Q,
   output logic       GAME_OVER,
   output logic [1:0] RESULT
);

   localparam logic [3:0] HP_INIT4  = 4'(HP_INIT);
   localparam logic [3:0] DMG4      = 4'(DMG);
   localparam logic [3:0] DRAW_DMG4 = 4'(DRAW_DMG);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PLAY     = 3'd1,
      S_HIT      = 3'd2,
      S_WAIT_CLR = 3'd3,
      S_OVER     = 3'd4
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [2:0] code;
   logic [3:0] my_dmg;
   logic [3:0] en_dmg;
   logic [3:0] my_hit;
   logic [3:0] en_hit;
   logic       wl_valid;
   logic       start_game;
   logic       next_q_set;

   function automatic logic [3:0] sat_sub(input logic [3:0] a, input logic [3:0] b);
      return (a > b) ? (a - b) : 4'd0;
   endfunction

   // Only 001/010/011 are round results; 000 and 1xx are ignored.
   assign wl_valid   = (WL_IN[2] == 1'b0) && (WL_IN[1:0] != 2'b00);
   assign start_game = ((state == S_IDLE) || (state == S_OVER)) && START;

   always_comb begin
      my_dmg = 4'd0;
      en_dmg = 4'd0;
      case (code)
         3'b001:  en_dmg = DMG4;
         3'b010:  my_dmg = DMG4;
         3'b011: begin
            my_dmg = DRAW_DMG4;
            en_dmg = DRAW_DMG4;
         end
         default: ;
      endcase
      my_hit = sat_sub(MY_HP, my_dmg);
      en_hit = sat_sub(EN_HP, en_dmg);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (START) state_nxt = S_PLAY;
         S_PLAY:     if (wl_valid) state_nxt = S_HIT;
         S_HIT:      state_nxt = ((my_hit == 4'd0) || (en_hit == 4'd0)) ? S_OVER : S_WAIT_CLR;
         S_WAIT_CLR: if (WL_IN == 3'b000) state_nxt = S_PLAY;
         S_OVER:     if (START) state_nxt = S_PLAY;
         default:    state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      ROUND_DONE = (state == S_HIT);
      GAME_OVER  = (state == S_OVER);
      RESULT     = 2'b00;
      if (state == S_OVER) begin
         RESULT = {MY_HP == 4'd0, EN_HP == 4'd0};
      end
      next_q_set = start_game || ((state == S_WAIT_CLR) && (WL_IN == 3'b000));
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         NEXT_Q <= 1'b0;
      end else begin
         NEXT_Q <= next_q_set;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         code <= 3'b000;
      end else if ((state == S_PLAY) && wl_valid) begin
         code <= WL_IN;
      end else if (state == S_HIT) begin
         code <= 3'b000;
      end
   end

   // HP is frozen in OVER until a restart reloads it.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         MY_HP <= HP_INIT4;
         EN_HP <= HP_INIT4;
      end else if ((state == S_IDLE) || start_game) begin
         MY_HP <= HP_INIT4;
         EN_HP <= HP_INIT4;
      end else if (state == S_HIT) begin
         MY_HP <= my_hit;
         EN_HP <= en_hit;
      end
   end

endmodule

// File: tb/tb_hp_manager.sv
// Bench for hp_manager: scoreboard of post-round HP plus directed checks on pulses, game end and reset.
module tb_hp_manager;

   logic       CLK;
   logic       RST;
   logic       START;
   logic [2:0] WL_IN;
   logic [3:0] MY_HP;
   logic [3:0] EN_HP;
   logic       ROUND_DONE;
   logic       NEXT_Q;
   logic       GAME_OVER;
   logic [1:0] RESULT;

   logic       ko_start, sat_start;
   logic [2:0] ko_wl, sat_wl;
   logic [3:0] ko_my, ko_en, sat_my, sat_en;
   logic       ko_rd, ko_nq, ko_go, sat_rd, sat_nq, sat_go;
   logic [1:0] ko_res, sat_res;

   int total = 0;
   int bad   = 0;
   int rd_cnt = 0;
   int nq_cnt = 0;
   int ovl_cnt = 0;
   logic rd_prev = 1'b0;
   logic [7:0] exp_q[$];
   logic [7:0] obs_q[$];
   int   m_my, m_en;
   logic m_over;

   hp_manager u_dut (
      .CLK(CLK), .RST(RST), .START(START), .WL_IN(WL_IN),
      .MY_HP(MY_HP), .EN_HP(EN_HP), .ROUND_DONE(ROUND_DONE),
      .NEXT_Q(NEXT_Q), .GAME_OVER(GAME_OVER), .RESULT(RESULT)
   );

   hp_manager #(.HP_INIT(1), .DMG(1), .DRAW_DMG(1)) u_ko (
      .CLK(CLK), .RST(RST), .START(ko_start), .WL_IN(ko_wl),
      .MY_HP(ko_my), .EN_HP(ko_en), .ROUND_DONE(ko_rd),
      .NEXT_Q(ko_nq), .GAME_OVER(ko_go), .RESULT(ko_res)
   );

   hp_manager #(.HP_INIT(2), .DMG(3), .DRAW_DMG(1)) u_sat (
      .CLK(CLK), .RST(RST), .START(sat_start), .WL_IN(sat_wl),
      .MY_HP(sat_my), .EN_HP(sat_en), .ROUND_DONE(sat_rd),
      .NEXT_Q(sat_nq), .GAME_OVER(sat_go), .RESULT(sat_res)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // HP is captured one cycle after each ROUND_DONE, when the update lands.
   always @(negedge CLK) begin
      if (!RST) begin
         rd_prev <= 1'b0;
      end else begin
         if (rd_prev) obs_q.push_back({MY_HP, EN_HP});
         rd_prev <= ROUND_DONE;
         if (ROUND_DONE) rd_cnt <= rd_cnt + 1;
         if (NEXT_Q) nq_cnt <= nq_cnt + 1;
         if (ROUND_DONE && NEXT_Q) ovl_cnt <= ovl_cnt + 1;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int sub_sat(input int a, input int b);
      return (a > b) ? (a - b) : 0;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic model_reset();
      m_my = 5;
      m_en = 5;
      m_over = 1'b0;
   endtask

   task automatic play_round(input logic [2:0] code, input int hold);
      WL_IN = code;
      if (!m_over) begin
         case (code)
            3'b001: m_en = sub_sat(m_en, 1);
            3'b010: m_my = sub_sat(m_my, 1);
            3'b011: begin
               m_my = sub_sat(m_my, 1);
               m_en = sub_sat(m_en, 1);
            end
            default: ;
         endcase
         exp_q.push_back({4'(m_my), 4'(m_en)});
         m_over = (m_my == 0) || (m_en == 0);
      end
      tick(hold);
      WL_IN = 3'b000;
      tick(2);
   endtask

   task automatic test_reset();
      RST = 1'b0; START = 1'b0; WL_IN = 3'b000;
      ko_start = 1'b0; ko_wl = 3'b000; sat_start = 1'b0; sat_wl = 3'b000;
      #12;
      total++;
      if ({MY_HP, EN_HP, ROUND_DONE, NEXT_Q, GAME_OVER, RESULT} !== {4'd5, 4'd5, 1'b0, 1'b0, 1'b0, 2'b00}) begin
         bad++;
         $display("FAIL reset_outputs: got my=%0d en=%0d rd=%b nq=%b go=%b res=%b, want 5 5 0 0 0 00",
                  MY_HP, EN_HP, ROUND_DONE, NEXT_Q, GAME_OVER, RESULT);
      end
      RST = 1'b1;
      model_reset();
   endtask

   task automatic test_basic_round();
      logic [7:0] e, o;
      int nq_b, rd_b;
      nq_b = nq_cnt; rd_b = rd_cnt;
      START = 1'b1;
      tick(1);
      START = 1'b0;
      total++;
      if (NEXT_Q !== 1'b1) begin bad++; $display("FAIL basic_start_nq: got %b want 1", NEXT_Q); end
      play_round(3'b001, 3);
      total++;
      if (NEXT_Q !== 1'b0 || GAME_OVER !== 1'b0 || RESULT !== 2'b00) begin
         bad++; $display("FAIL basic_idle_outputs: got nq=%b go=%b res=%b want 0 0 00", NEXT_Q, GAME_OVER, RESULT);
      end
      total++;
      if (rd_cnt - rd_b !== 1) begin bad++; $display("FAIL basic_rd_count: got %0d want 1", rd_cnt - rd_b); end
      total++;
      if (nq_cnt - nq_b !== 2) begin bad++; $display("FAIL basic_nq_count: got %0d want 2", nq_cnt - nq_b); end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         total++;
         if (obs_q.size() == 0) begin
            bad++; $display("FAIL basic_sb: no update seen, want my=%0d en=%0d", e[7:4], e[3:0]);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin bad++; $display("FAIL basic_sb: got my=%0d en=%0d want my=%0d en=%0d", o[7:4], o[3:0], e[7:4], e[3:0]); end
         end
      end
   endtask

   task automatic test_held_input();
      logic [7:0] e, o;
      int nq_b, rd_b;
      nq_b = nq_cnt; rd_b = rd_cnt;
      play_round(3'b010, 10);
      total++;
      if (rd_cnt - rd_b !== 1) begin bad++; $display("FAIL held_rd_count: got %0d want 1", rd_cnt - rd_b); end
      total++;
      if (nq_cnt - nq_b !== 1) begin bad++; $display("FAIL held_nq_count: got %0d want 1 (only after clear)", nq_cnt - nq_b); end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         total++;
         if (obs_q.size() == 0) begin
            bad++; $display("FAIL held_sb: no update seen, want my=%0d en=%0d", e[7:4], e[3:0]);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin bad++; $display("FAIL held_sb: got my=%0d en=%0d want my=%0d en=%0d", o[7:4], o[3:0], e[7:4], e[3:0]); end
         end
      end
      total++;
      if ({MY_HP, EN_HP} !== {4'd4, 4'd4}) begin bad++; $display("FAIL held_hp: got my=%0d en=%0d want 4 4", MY_HP, EN_HP); end
   endtask

   task automatic test_enemy_win();
      logic [7:0] e, o;
      int nq_b, rd_b;
      RST = 1'b0;
      tick(1);
      RST = 1'b1;
      model_reset();
      nq_b = nq_cnt;
      START = 1'b1;
      tick(1);
      START = 1'b0;
      for (int i = 0; i < 5; i++) play_round(3'b010, 2);
      total++;
      if (nq_cnt - nq_b !== 5) begin bad++; $display("FAIL win_nq_count: got %0d want 5", nq_cnt - nq_b); end
      total++;
      if ({MY_HP, EN_HP, GAME_OVER, RESULT} !== {4'd0, 4'd5, 1'b1, 2'b10}) begin
         bad++; $display("FAIL win_over: got my=%0d en=%0d go=%b res=%b want 0 5 1 10", MY_HP, EN_HP, GAME_OVER, RESULT);
      end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         total++;
         if (obs_q.size() == 0) begin
            bad++; $display("FAIL win_sb: no update seen, want my=%0d en=%0d", e[7:4], e[3:0]);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin bad++; $display("FAIL win_sb: got my=%0d en=%0d want my=%0d en=%0d", o[7:4], o[3:0], e[7:4], e[3:0]); end
         end
      end
      nq_b = nq_cnt; rd_b = rd_cnt;
      WL_IN = 3'b001; tick(4);
      WL_IN = 3'b011; tick(4);
      WL_IN = 3'b000; tick(2);
      total++;
      if ({MY_HP, EN_HP, GAME_OVER, RESULT} !== {4'd0, 4'd5, 1'b1, 2'b10}) begin
         bad++; $display("FAIL win_frozen: got my=%0d en=%0d go=%b res=%b want 0 5 1 10", MY_HP, EN_HP, GAME_OVER, RESULT);
      end
      total++;
      if ((rd_cnt - rd_b) + (nq_cnt - nq_b) !== 0) begin
         bad++; $display("FAIL win_no_pulses: got rd=%0d nq=%0d want 0 0", rd_cnt - rd_b, nq_cnt - nq_b);
      end
   endtask

   task automatic test_invalid_restart();
      logic [7:0] e, o;
      int nq_b, rd_b;
      nq_b = nq_cnt; rd_b = rd_cnt;
      START = 1'b1;
      tick(1);
      model_reset();
      total++;
      if ({MY_HP, EN_HP, GAME_OVER, RESULT, NEXT_Q} !== {4'd5, 4'd5, 1'b0, 2'b00, 1'b1}) begin
         bad++; $display("FAIL restart: got my=%0d en=%0d go=%b res=%b nq=%b want 5 5 0 00 1", MY_HP, EN_HP, GAME_OVER, RESULT, NEXT_Q);
      end
      // START stays high through invalid codes and a full round: it must be ignored.
      WL_IN = 3'b100; tick(3);
      WL_IN = 3'b111; tick(3);
      WL_IN = 3'b000; tick(1);
      total++;
      if ({MY_HP, EN_HP} !== {4'd5, 4'd5} || rd_cnt != rd_b) begin
         bad++; $display("FAIL invalid_code: got my=%0d en=%0d rd=%0d want 5 5 0", MY_HP, EN_HP, rd_cnt - rd_b);
      end
      play_round(3'b001, 2);
      START = 1'b0;
      total++;
      if (nq_cnt - nq_b !== 2) begin bad++; $display("FAIL start_ignored_nq: got %0d want 2", nq_cnt - nq_b); end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         total++;
         if (obs_q.size() == 0) begin
            bad++; $display("FAIL restart_sb: no update seen, want my=%0d en=%0d", e[7:4], e[3:0]);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin bad++; $display("FAIL restart_sb: got my=%0d en=%0d want my=%0d en=%0d", o[7:4], o[3:0], e[7:4], e[3:0]); end
         end
      end
   endtask

   task automatic test_reset_in_hit();
      logic [7:0] e, o;
      WL_IN = 3'b010;
      tick(1);
      total++;
      if (ROUND_DONE !== 1'b1) begin bad++; $display("FAIL hit_reached: got rd=%b want 1", ROUND_DONE); end
      #1 RST = 1'b0;
      #1;
      total++;
      if ({MY_HP, EN_HP, ROUND_DONE, NEXT_Q, GAME_OVER, RESULT} !== {4'd5, 4'd5, 1'b0, 1'b0, 1'b0, 2'b00}) begin
         bad++; $display("FAIL async_reset: got my=%0d en=%0d rd=%b nq=%b go=%b res=%b want 5 5 0 0 0 00",
                         MY_HP, EN_HP, ROUND_DONE, NEXT_Q, GAME_OVER, RESULT);
      end
      WL_IN = 3'b000;
      tick(1);
      RST = 1'b1;
      START = 1'b1;
      model_reset();
      tick(1);
      START = 1'b0;
      total++;
      if ({NEXT_Q, MY_HP, EN_HP} !== {1'b1, 4'd5, 4'd5}) begin
         bad++; $display("FAIL first_start_after_reset: got nq=%b my=%0d en=%0d want 1 5 5", NEXT_Q, MY_HP, EN_HP);
      end
      total++;
      if (obs_q.size() != 0) begin bad++; $display("FAIL hit_discarded: got %0d stray updates want 0", obs_q.size()); end
      play_round(3'b001, 2);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         total++;
         if (obs_q.size() == 0) begin
            bad++; $display("FAIL post_reset_sb: no update seen, want my=%0d en=%0d", e[7:4], e[3:0]);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin bad++; $display("FAIL post_reset_sb: got my=%0d en=%0d want my=%0d en=%0d", o[7:4], o[3:0], e[7:4], e[3:0]); end
         end
      end
   endtask

   task automatic test_double_ko();
      ko_start = 1'b1;
      tick(1);
      ko_start = 1'b0;
      ko_wl = 3'b011;
      tick(2);
      ko_wl = 3'b000;
      total++;
      if ({ko_my, ko_en, ko_go, ko_res} !== {4'd0, 4'd0, 1'b1, 2'b11}) begin
         bad++; $display("FAIL double_ko: got my=%0d en=%0d go=%b res=%b want 0 0 1 11", ko_my, ko_en, ko_go, ko_res);
      end
   endtask

   task automatic test_saturate();
      sat_start = 1'b1;
      tick(1);
      sat_start = 1'b0;
      sat_wl = 3'b001;
      tick(2);
      sat_wl = 3'b000;
      total++;
      if ({sat_my, sat_en, sat_go, sat_res} !== {4'd2, 4'd0, 1'b1, 2'b01}) begin
         bad++; $display("FAIL saturate: got my=%0d en=%0d go=%b res=%b want 2 0 1 01", sat_my, sat_en, sat_go, sat_res);
      end
   endtask

   task automatic test_pulse_exclusive();
      total++;
      if (ovl_cnt != 0) begin bad++; $display("FAIL pulse_overlap: got %0d overlapping cycles want 0", ovl_cnt); end
   endtask

   initial begin
      test_reset();
      test_basic_round();
      test_held_input();
      test_enemy_win();
      test_invalid_restart();
      test_reset_in_hit();
      test_double_ko();
      test_saturate();
      test_pulse_exclusive();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
